// File: rtl/iram_loader_if.sv
// Byte-stream input and IRAM write-port signals of the boot loader.
// master: stream source / observer side, slave: the loader itself.
interface iram_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_rst;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err
    );
endinterface

// File: rtl/iram_loader.sv
// Boot-time IRAM loader: parses a length header, assembles big-endian
// 32-bit words, writes them into IRAM and releases the core from reset
// only once the XOR checksum over header and data matches.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_LEN_HI | waiting for word-count high byte
// S_LEN_LO | waiting for word-count low byte, range check
// S_DATA   | assembling instruction words, one write per 4 bytes
// S_CSUM   | waiting for checksum byte
// S_DONE   | image verified, core released (terminal)
// S_ERR    | oversize image or bad checksum (terminal)
module iram_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    iram_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    // Largest word count that fits between BASE and the top of IRAM.
    localparam longint CAP = (longint'(1) << ADDR_W) - longint'(BASE_ADDR);

    state_t            state, state_n;
    logic [7:0]        len_hi, len_hi_n;
    logic [15:0]       len, len_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [15:0]       word_cnt, word_cnt_n;
    // Only the first three bytes of a word need holding; the fourth
    // is concatenated directly when the word is registered.
    logic [23:0]       asm_reg, asm_n;
    logic [7:0]        xsum, xsum_n;

    logic              in_ready, in_ready_n;
    logic              wr_en, wr_en_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic [31:0]       wr_data, wr_data_n;
    logic              cpu_rst, cpu_rst_n;
    logic              done, done_n;
    logic              err, err_n;

    logic              xfer;
    logic [15:0]       len_rx;

    assign xfer   = bus.in_valid && in_ready;
    assign len_rx = {len_hi, bus.in_data};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LEN_HI;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_n    = state;
        len_hi_n   = len_hi;
        len_n      = len;
        byte_cnt_n = byte_cnt;
        word_cnt_n = word_cnt;
        asm_n      = asm_reg;
        xsum_n     = xsum;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        cpu_rst_n  = cpu_rst;
        done_n     = done;
        err_n      = err;

        case (state)
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_n = bus.in_data;
                    xsum_n   = xsum ^ bus.in_data;
                    state_n  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_n  = len_rx;
                    xsum_n = xsum ^ bus.in_data;
                    if (64'(len_rx) > CAP) begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                    end else if (len_rx == 16'd0) begin
                        state_n = S_CSUM;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_n      = {asm_reg[15:0], bus.in_data};
                    xsum_n     = xsum ^ bus.in_data;
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        wr_en_n    = 1'b1;
                        wr_data_n  = {asm_reg, bus.in_data};
                        wr_addr_n  = BASE + ADDR_W'(word_cnt);
                        word_cnt_n = word_cnt + 16'd1;
                        if (word_cnt + 16'd1 == len) begin
                            state_n = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (bus.in_data == xsum) begin
                        state_n   = S_DONE;
                        done_n    = 1'b1;
                        cpu_rst_n = 1'b0;
                    end else begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_DONE;
            end
            S_ERR: begin
                state_n = S_ERR;
            end
            default: begin
                state_n = S_ERR;
                err_n   = 1'b1;
            end
        endcase

        // in_ready is registered from the next state so it never depends
        // combinationally on the stream inputs.
        in_ready_n = (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                     (state_n == S_DATA)   || (state_n == S_CSUM);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi   <= 8'd0;
            len      <= 16'd0;
            byte_cnt <= 2'd0;
            word_cnt <= 16'd0;
            asm_reg  <= 24'd0;
            xsum     <= 8'd0;
            in_ready <= 1'b1;
            wr_en    <= 1'b0;
            wr_addr  <= BASE;
            wr_data  <= 32'd0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            len_hi   <= len_hi_n;
            len      <= len_n;
            byte_cnt <= byte_cnt_n;
            word_cnt <= word_cnt_n;
            asm_reg  <= asm_n;
            xsum     <= xsum_n;
            in_ready <= in_ready_n;
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            cpu_rst  <= cpu_rst_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign bus.cpu_rst  = cpu_rst;
    assign bus.done     = done;
    assign bus.err      = err;

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: expected IRAM writes are queued
// as bytes are driven and retired by a monitor when wr_en is observed.
module tb_iram_loader;

    localparam int ADDR_W    = 8;
    localparam int BASE_ADDR = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    iram_loader_if #(.ADDR_W(ADDR_W)) bus ();

    iram_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                due;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] words[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          wr_seen     = 0;
    logic        wr_prev     = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: retire queued writes, catch extra, late, missing or back-to-back strobes.
    always @(negedge clk) begin
        if (rst) begin
            wr_prev <= 1'b0;
        end else begin
            if (bus.wr_en) begin
                wr_seen <= wr_seen + 1;
                chk("wr_b2b", 64'(wr_prev), 64'd0);
                chk("wr_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(bus.wr_data), 64'(e.data));
                    chk("wr_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                void'(sb.pop_front());
                chk("wr_missing", 64'(bus.wr_en), 64'd1);
            end
            wr_prev <= bus.wr_en;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_wr_en"},    64'(bus.wr_en),    64'd0);
        chk({tag, "_wr_addr"},  64'(bus.wr_addr),  64'(BASE_ADDR));
        chk({tag, "_wr_data"},  64'(bus.wr_data),  64'd0);
        chk({tag, "_cpu_rst"},  64'(bus.cpu_rst),  64'd1);
        chk({tag, "_done"},     64'(bus.done),     64'd0);
        chk({tag, "_err"},      64'(bus.err),      64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        sb.delete();
        chk_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int idle;
        idle = 0;
        if (stall) idle = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 8) : $urandom_range(0, 1);
        repeat (idle) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
    endtask

    task automatic send_junk(input int k);
        repeat (k) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Stream the image in words[] (n words). csum_force < 0 sends the correct checksum.
    task automatic load(input string tag, input int n, input int csum_force, input bit stall);
        logic [7:0] x;
        logic [7:0] b;
        logic [7:0] cs;
        logic [31:0] w;
        logic [15:0] n16;
        int base;
        bit ok;
        base = wr_seen;
        x    = 8'd0;
        n16  = 16'(n);
        send_byte(n16[15:8], stall); x = x ^ n16[15:8];
        send_byte(n16[7:0], stall);  x = x ^ n16[7:0];
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                b = w[31 - 8*j -: 8];
                send_byte(b, stall);
                x = x ^ b;
                if (j == 3) sb.push_back('{addr: ADDR_W'(BASE_ADDR + i), data: w, due: cyc + 1});
            end
        end
        cs = (csum_force < 0) ? x : 8'(csum_force);
        ok = (cs == x);
        send_byte(cs, stall);
        chk({tag, "_done_early"}, 64'(bus.done), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_done"},     64'(bus.done),     64'(ok));
        chk({tag, "_err"},      64'(bus.err),      64'(!ok));
        chk({tag, "_cpu_rst"},  64'(bus.cpu_rst),  64'(!ok));
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_wr_count"}, 64'(wr_seen - base), 64'(n));
        chk({tag, "_sb_empty"}, 64'(sb.size()),      64'd0);
    endtask

    task automatic two_words();
        words.delete();
        words.push_back(32'h2008_0005);
        words.push_back(32'hAC09_0004);
    endtask

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        #2 rst = 1'b1;
        #1 chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;

        // Two-word image, continuous stream.
        two_words();
        load("good", 2, -1, 1'b0);

        // Bad checksum: both writes, then err and bytes ignored.
        do_reset();
        two_words();
        load("badcs", 2, 8'h22, 1'b0);
        base = wr_seen;
        send_junk(6);
        repeat (2) @(negedge clk);
        chk("badcs_err_hold",  64'(bus.err),      64'd1);
        chk("badcs_cpu_rst",   64'(bus.cpu_rst),  64'd1);
        chk("badcs_in_ready",  64'(bus.in_ready), 64'd0);
        chk("badcs_no_writes", 64'(wr_seen - base), 64'd0);

        // Oversize header N = 257 with 256-word IRAM.
        do_reset();
        base = wr_seen;
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ovr_err",      64'(bus.err),      64'd1);
        chk("ovr_in_ready", 64'(bus.in_ready), 64'd0);
        chk("ovr_cpu_rst",  64'(bus.cpu_rst),  64'd1);
        chk("ovr_done",     64'(bus.done),     64'd0);
        send_junk(8);
        repeat (2) @(negedge clk);
        chk("ovr_no_writes", 64'(wr_seen - base), 64'd0);

        // Empty image, good then bad checksum.
        do_reset();
        words.delete();
        load("empty_ok", 0, 8'h00, 1'b0);
        do_reset();
        load("empty_bad", 0, 8'h01, 1'b0);

        // Stalled stream with random gaps.
        do_reset();
        two_words();
        load("stall", 2, -1, 1'b1);

        // Reset right after the 6th byte, during the first word's write cycle.
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        sb.delete();
        chk_reset_vals("mid");
        @(negedge clk);
        rst = 1'b0;
        two_words();
        load("reload", 2, -1, 1'b0);

        // Largest image that fits: 256 words ending at the top address.
        do_reset();
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back($urandom);
        load("full", 256, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
